// File: rtl/glitch_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// glitch_sweep_sequencer
//   Drives the CPU-reset glitcher across repeated console boot attempts. It
//   counts synchronised POST-bit edges and opens a fixed glitch window at the
//   target transition. It then watches further POST activity to judge the
//   attempt. A failed attempt hard-resets the console and steps the
//   (cfg_start, cfg_len) sweep point.
//
// Ports
//   clk_96m     in   1   system clock, posedge only
//   rst         in   1   asynchronous active-high reset
//   enable      in   1   sequencer runs while high
//   post_bit    in   1   raw asynchronous POST bit from the console
//   glitch      out  1   glitch window request to the glitcher
//   cfg_start   out  16  glitch start tick count for the glitcher
//   cfg_len     out  3   glitch length in ticks for the glitcher
//   hard_reset  out  1   active-high console reset drive
//   busy        out  1   high outside IDLE / DONE / FAIL
//   success     out  1   sticky, high in DONE
//   fail        out  1   sticky, high in FAIL (sweep exhausted)
//   try_cnt     out  16  attempts started since leaving IDLE, saturating
// -----------------------------------------------------------------------------
module glitch_sweep_sequencer #(
   parameter int unsigned POST_TARGET   = 8,
   parameter int unsigned WIN_CYCLES    = 16384,
   parameter int unsigned SUCCESS_EDGES = 4,
   parameter int unsigned TIMEOUT       = 9600000,
   parameter int unsigned RESET_CYCLES  = 960000,
   parameter int unsigned START_MIN     = 34700,
   parameter int unsigned START_MAX     = 34740,
   parameter int unsigned START_STEP    = 1,
   parameter int unsigned LEN_MAX       = 4
) (
   input  logic        clk_96m,
   input  logic        rst,
   input  logic        enable,
   input  logic        post_bit,
   output logic        glitch,
   output logic [15:0] cfg_start,
   output logic [2:0]  cfg_len,
   output logic        hard_reset,
   output logic        busy,
   output logic        success,
   output logic        fail,
   output logic [15:0] try_cnt
);

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned TMR_W    = 24;
   localparam int unsigned START_W  = 16;
   localparam int unsigned START_XW = START_W + 1;
   localparam int unsigned LEN_W    = 3;
   localparam int unsigned LEN_XW   = LEN_W + 1;
   localparam int unsigned TRY_W    = 16;

   localparam logic [CNT_W-1:0]    POST_TGT     = CNT_W'(POST_TARGET);
   localparam logic [CNT_W-1:0]    SUCC_TGT     = CNT_W'(SUCCESS_EDGES);
   localparam logic [TMR_W-1:0]    WIN_LAST     = TMR_W'(WIN_CYCLES - 1);
   localparam logic [TMR_W-1:0]    TO_LAST      = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]    RST_LAST     = TMR_W'(RESET_CYCLES - 1);
   localparam logic [START_W-1:0]  START_MIN_C  = START_W'(START_MIN);
   localparam logic [START_XW-1:0] START_MAX_X  = START_XW'(START_MAX);
   localparam logic [START_XW-1:0] START_STEP_X = START_XW'(START_STEP);
   localparam logic [LEN_XW-1:0]   LEN_MAX_X    = LEN_XW'(LEN_MAX);
   localparam logic [LEN_W-1:0]    LEN_MIN_C    = LEN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_POST,
      S_ARM,
      S_OBSERVE,
      S_RESET,
      S_DONE,
      S_FAIL
   } state_e;

   state_e               state_q, state_d;
   logic [2:0]           sync_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 glitch_q, glitch_d;
   logic                 hard_reset_q, hard_reset_d;
   logic                 busy_q, busy_d;
   logic                 success_q, success_d;
   logic                 fail_q, fail_d;
   logic                 sweep_end_q, sweep_end_d;
   logic [START_W-1:0]   cfg_start_q, cfg_start_d;
   logic [LEN_W-1:0]     cfg_len_q, cfg_len_d;
   logic [TRY_W-1:0]     try_cnt_q, try_cnt_d;

   logic                 edge_c;
   logic [START_XW-1:0]  start_sum_c;
   logic [LEN_XW-1:0]    len_sum_c;
   logic                 start_wrap_c;
   logic                 len_over_c;
   logic [TRY_W-1:0]     try_inc_c;

   // Two-flop synchroniser plus a third flop for edge detection
   always_ff @(posedge clk_96m or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], post_bit};
      end
   end

   assign edge_c = sync_q[1] ^ sync_q[2];

   // Next sweep point; the 17-bit sum makes 16-bit overflow count as a wrap
   always_comb begin
      start_sum_c  = {1'b0, cfg_start_q} + START_STEP_X;
      len_sum_c    = {1'b0, cfg_len_q} + LEN_XW'(1);
      start_wrap_c = (start_sum_c > START_MAX_X);
      len_over_c   = (len_sum_c > LEN_MAX_X);
      try_inc_c    = (try_cnt_q == '1) ? try_cnt_q : try_cnt_q + TRY_W'(1);
   end

   // State and output registers
   always_ff @(posedge clk_96m or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         timer_q      <= '0;
         glitch_q     <= 1'b0;
         hard_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         success_q    <= 1'b0;
         fail_q       <= 1'b0;
         sweep_end_q  <= 1'b0;
         cfg_start_q  <= START_MIN_C;
         cfg_len_q    <= LEN_MIN_C;
         try_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         glitch_q     <= glitch_d;
         hard_reset_q <= hard_reset_d;
         busy_q       <= busy_d;
         success_q    <= success_d;
         fail_q       <= fail_d;
         sweep_end_q  <= sweep_end_d;
         cfg_start_q  <= cfg_start_d;
         cfg_len_q    <= cfg_len_d;
         try_cnt_q    <= try_cnt_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timer_d      = timer_q;
      glitch_d     = 1'b0;
      hard_reset_d = 1'b0;
      success_d    = success_q;
      fail_d       = fail_q;
      sweep_end_d  = sweep_end_q;
      cfg_start_d  = cfg_start_q;
      cfg_len_d    = cfg_len_q;
      try_cnt_d    = try_cnt_q;

      if ((state_q != S_IDLE) && !enable) begin
         // Leaving for IDLE restores every output to its reset value
         state_d     = S_IDLE;
         cnt_d       = '0;
         timer_d     = '0;
         success_d   = 1'b0;
         fail_d      = 1'b0;
         sweep_end_d = 1'b0;
         cfg_start_d = START_MIN_C;
         cfg_len_d   = LEN_MIN_C;
         try_cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_d     = S_WAIT_POST;
                  cnt_d       = '0;
                  timer_d     = '0;
                  sweep_end_d = 1'b0;
                  cfg_start_d = START_MIN_C;
                  cfg_len_d   = LEN_MIN_C;
                  try_cnt_d   = try_inc_c;
               end
            end

            S_WAIT_POST: begin
               if (cnt_q >= POST_TGT) begin
                  state_d  = S_ARM;
                  glitch_d = 1'b1;
                  timer_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(edge_c);
               end
            end

            S_ARM: begin
               if (timer_q == WIN_LAST) begin
                  state_d = S_OBSERVE;
                  cnt_d   = '0;
                  timer_d = '0;
               end else begin
                  timer_d  = timer_q + TMR_W'(1);
                  glitch_d = 1'b1;
               end
            end

            // Edge count is checked before the timeout so a tie is a success
            S_OBSERVE: begin
               if (cnt_q >= SUCC_TGT) begin
                  state_d   = S_DONE;
                  success_d = 1'b1;
               end else if (timer_q == TO_LAST) begin
                  state_d      = S_RESET;
                  hard_reset_d = 1'b1;
                  timer_d      = '0;
                  if (start_wrap_c) begin
                     if (len_over_c) begin
                        sweep_end_d = 1'b1;
                     end else begin
                        cfg_start_d = START_MIN_C;
                        cfg_len_d   = len_sum_c[LEN_W-1:0];
                     end
                  end else begin
                     cfg_start_d = start_sum_c[START_W-1:0];
                  end
               end else begin
                  timer_d = timer_q + TMR_W'(1);
                  cnt_d   = cnt_q + CNT_W'(edge_c);
               end
            end

            S_RESET: begin
               if (timer_q == RST_LAST) begin
                  timer_d = '0;
                  cnt_d   = '0;
                  if (sweep_end_q) begin
                     state_d = S_FAIL;
                     fail_d  = 1'b1;
                  end else begin
                     state_d   = S_WAIT_POST;
                     try_cnt_d = try_inc_c;
                  end
               end else begin
                  timer_d      = timer_q + TMR_W'(1);
                  hard_reset_d = 1'b1;
               end
            end

            S_DONE: begin
               state_d = S_DONE;
            end

            S_FAIL: begin
               state_d = S_FAIL;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_WAIT_POST) || (state_d == S_ARM) ||
               (state_d == S_OBSERVE)   || (state_d == S_RESET);
   end

   assign glitch     = glitch_q;
   assign hard_reset = hard_reset_q;
   assign busy       = busy_q;
   assign success    = success_q;
   assign fail       = fail_q;
   assign cfg_start  = cfg_start_q;
   assign cfg_len    = cfg_len_q;
   assign try_cnt    = try_cnt_q;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_glitch_sweep_sequencer
//   Scenario tasks drive post_bit / enable / rst. Each expected glitch-window
//   configuration is queued before the attempt is armed. A monitor pops and
//   compares it when glitch rises, and it also checks the window width and
//   glitch/hard_reset exclusivity.
// -----------------------------------------------------------------------------
module tb_glitch_sweep_sequencer;

   localparam int unsigned WIN = 8;

   typedef struct packed {
      logic [15:0] start;
      logic [2:0]  len;
      logic [15:0] tries;
   } exp_t;

   logic        clk_96m;
   logic        rst;
   logic        enable;
   logic        post_bit;
   logic        glitch;
   logic [15:0] cfg_start;
   logic [2:0]  cfg_len;
   logic        hard_reset;
   logic        busy;
   logic        success;
   logic        fail;
   logic [15:0] try_cnt;

   int   tests_run    = 0;
   int   tests_failed = 0;
   exp_t exp_q[$];
   bit   allow_trunc  = 1'b0;
   bit   glitch_prev  = 1'b0;
   int   win_len      = 0;

   glitch_sweep_sequencer #(
      .POST_TARGET  (3),
      .WIN_CYCLES   (8),
      .SUCCESS_EDGES(2),
      .TIMEOUT      (50),
      .RESET_CYCLES (4),
      .START_MIN    (100),
      .START_MAX    (120),
      .START_STEP   (10),
      .LEN_MAX      (2)
   ) dut (
      .clk_96m   (clk_96m),
      .rst       (rst),
      .enable    (enable),
      .post_bit  (post_bit),
      .glitch    (glitch),
      .cfg_start (cfg_start),
      .cfg_len   (cfg_len),
      .hard_reset(hard_reset),
      .busy      (busy),
      .success   (success),
      .fail      (fail),
      .try_cnt   (try_cnt)
   );

   initial clk_96m = 1'b0;
   always #5 clk_96m = ~clk_96m;

   // Window monitor: scoreboard pop on glitch rise, width on fall
   always begin
      exp_t e;
      @(posedge clk_96m);
      #1;
      tests_run++;
      if (glitch && hard_reset) begin
         tests_failed++;
         $display("FAIL exclusive: glitch=%0b hard_reset=%0b at %0t", glitch, hard_reset, $time);
      end
      if (glitch && !glitch_prev) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL window_cfg: unexpected window cfg_start=%0d cfg_len=%0d try_cnt=%0d",
                     cfg_start, cfg_len, try_cnt);
         end else begin
            e = exp_q.pop_front();
            if ({cfg_start, cfg_len, try_cnt} !== {e.start, e.len, e.tries}) begin
               tests_failed++;
               $display("FAIL window_cfg: got start=%0d len=%0d try=%0d, want start=%0d len=%0d try=%0d",
                        cfg_start, cfg_len, try_cnt, e.start, e.len, e.tries);
            end
         end
         win_len = 1;
      end else if (glitch) begin
         win_len++;
      end
      if (!glitch && glitch_prev && !allow_trunc) begin
         tests_run++;
         if (win_len != WIN) begin
            tests_failed++;
            $display("FAIL window_width: got %0d cycles, want %0d", win_len, WIN);
         end
      end
      glitch_prev = glitch;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_96m);
         #1;
      end
   endtask

   // Queue the expected window config, then give the three arming POST edges
   task automatic arm_attempt(input logic [15:0] s, input logic [2:0] l, input logic [15:0] t);
      exp_t e;
      e.start = s;
      e.len   = l;
      e.tries = t;
      exp_q.push_back(e);
      post_bit = ~post_bit;
      tick(2);
      post_bit = ~post_bit;
      tick(2);
      post_bit = ~post_bit;
   endtask

   task automatic wait_glitch_fall(output bit ok);
      bit seen;
      seen = 1'b0;
      ok   = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (glitch) seen = 1'b1;
         else if (seen) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_hr(input logic lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (hard_reset === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = 1'b0;
      post_bit = 1'b0;
      tick(2);
      tests_run++;
      if ({glitch, hard_reset, busy, success, fail} !== 5'b0 || try_cnt !== 16'd0 ||
          cfg_start !== 16'd100 || cfg_len !== 3'd1) begin
         tests_failed++;
         $display("FAIL reset_state: flags=%b try=%0d start=%0d len=%0d, want 00000 0 100 1",
                  {glitch, hard_reset, busy, success, fail}, try_cnt, cfg_start, cfg_len);
      end
      rst = 1'b0;
      tick(3);
      tests_run++;
      if ({glitch, hard_reset, busy, success, fail} !== 5'b0 || try_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL idle_hold: flags=%b try=%0d, want 00000 0",
                  {glitch, hard_reset, busy, success, fail}, try_cnt);
      end
   endtask

   task automatic test_glitch_window();
      exp_t e;
      enable = 1'b1;
      tick(1);
      tests_run++;
      if (busy !== 1'b1 || try_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL start_attempt: busy=%0b try=%0d, want 1 1", busy, try_cnt);
      end
      e.start = 16'd100;
      e.len   = 3'd1;
      e.tries = 16'd1;
      exp_q.push_back(e);
      post_bit = ~post_bit;
      tick(2);
      post_bit = ~post_bit;
      tick(2);
      post_bit = ~post_bit;
      tick(3);
      tests_run++;
      if (glitch !== 1'b0) begin
         tests_failed++;
         $display("FAIL glitch_early: glitch=%0b 3 cycles after 3rd edge, want 0", glitch);
      end
      tick(1);
      tests_run++;
      if (glitch !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_rise: glitch=%0b 4 cycles after 3rd edge, want 1", glitch);
      end
      tick(7);
      tests_run++;
      if (glitch !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_hold: glitch=%0b in 8th window cycle, want 1", glitch);
      end
      tick(1);
      tests_run++;
      if (glitch !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL glitch_close: glitch=%0b busy=%0b, want 0 1", glitch, busy);
      end
   endtask

   // Starts on the first OBSERVE cycle left by test_glitch_window
   task automatic test_success();
      post_bit = ~post_bit;
      tick(3);
      post_bit = ~post_bit;
      tick(4);
      tests_run++;
      if ({success, busy, hard_reset} !== 3'b100 || cfg_start !== 16'd100 || cfg_len !== 3'd1) begin
         tests_failed++;
         $display("FAIL success: s/b/hr=%b start=%0d len=%0d, want 100 100 1",
                  {success, busy, hard_reset}, cfg_start, cfg_len);
      end
      tick(5);
      tests_run++;
      if (success !== 1'b1 || cfg_start !== 16'd100) begin
         tests_failed++;
         $display("FAIL success_hold: success=%0b start=%0d, want 1 100", success, cfg_start);
      end
      enable = 1'b0;
      tick(1);
      tests_run++;
      if (success !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL success_clear: success=%0b busy=%0b, want 0 0", success, busy);
      end
      tick(4);
   endtask

   task automatic test_timeout_rearm();
      bit ok;
      enable = 1'b1;
      tick(1);
      arm_attempt(16'd100, 3'd1, 16'd1);
      wait_glitch_fall(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL timeout_window: window never closed, got 0 want 1");
      end
      tick(49);
      tests_run++;
      if (hard_reset !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL observe_len: hard_reset=%0b busy=%0b after 49 cycles, want 0 1", hard_reset, busy);
      end
      tick(1);
      tests_run++;
      if (hard_reset !== 1'b1 || cfg_start !== 16'd110 || cfg_len !== 3'd1 || try_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL timeout_reset: hr=%0b start=%0d len=%0d try=%0d, want 1 110 1 1",
                  hard_reset, cfg_start, cfg_len, try_cnt);
      end
      tick(3);
      tests_run++;
      if (hard_reset !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_pulse_hold: hard_reset=%0b in 4th cycle, want 1", hard_reset);
      end
      tick(1);
      tests_run++;
      if (hard_reset !== 1'b0 || try_cnt !== 16'd2 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_pulse_end: hr=%0b try=%0d busy=%0b, want 0 2 1", hard_reset, try_cnt, busy);
      end
      arm_attempt(16'd110, 3'd1, 16'd2);
      wait_glitch_fall(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL rearm: second window not seen, got 0 want 1");
      end
      enable = 1'b0;
      tick(4);
   endtask

   task automatic test_sweep_fail();
      bit          ok;
      bit          exhausted;
      logic [15:0] s, ns;
      logic [2:0]  l, nl;
      s = 16'd100;
      l = 3'd1;
      enable = 1'b1;
      tick(1);
      for (int i = 0; i < 6; i++) begin
         arm_attempt(s, l, 16'(i + 1));
         wait_glitch_fall(ok);
         tests_run++;
         if (!ok) begin
            tests_failed++;
            $display("FAIL sweep_window: attempt %0d window not seen", i + 1);
         end
         ns = s + 16'd10;
         nl = l;
         if (ns > 16'd120) begin
            ns = 16'd100;
            nl = l + 3'd1;
         end
         exhausted = (nl > 3'd2);
         wait_hr(1'b1, ok);
         tests_run++;
         if (!ok || cfg_start !== (exhausted ? s : ns) || cfg_len !== (exhausted ? l : nl)) begin
            tests_failed++;
            $display("FAIL sweep_step: attempt %0d hr_seen=%0b start=%0d len=%0d, want %0d %0d",
                     i + 1, ok, cfg_start, cfg_len, exhausted ? s : ns, exhausted ? l : nl);
         end
         wait_hr(1'b0, ok);
         tests_run++;
         if (exhausted) begin
            if (!ok || {fail, busy, success} !== 3'b100 || try_cnt !== 16'd6 ||
                cfg_start !== 16'd120 || cfg_len !== 3'd2) begin
               tests_failed++;
               $display("FAIL sweep_exhaust: f/b/s=%b try=%0d start=%0d len=%0d, want 100 6 120 2",
                        {fail, busy, success}, try_cnt, cfg_start, cfg_len);
            end
         end else begin
            if (!ok || try_cnt !== 16'(i + 2) || busy !== 1'b1 || fail !== 1'b0) begin
               tests_failed++;
               $display("FAIL sweep_retry: attempt %0d try=%0d busy=%0b fail=%0b, want %0d 1 0",
                        i + 1, try_cnt, busy, fail, i + 2);
            end
         end
         s = ns;
         l = nl;
      end
      tick(5);
      tests_run++;
      if (fail !== 1'b1 || hard_reset !== 1'b0) begin
         tests_failed++;
         $display("FAIL fail_hold: fail=%0b hr=%0b, want 1 0", fail, hard_reset);
      end
      enable = 1'b0;
      tick(1);
      tests_run++;
      if (fail !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL fail_clear: fail=%0b busy=%0b, want 0 0", fail, busy);
      end
      tick(4);
   endtask

   // Second success edge counted on the last OBSERVE cycle
   task automatic test_success_timeout_tie();
      bit ok;
      enable = 1'b1;
      tick(1);
      arm_attempt(16'd100, 3'd1, 16'd1);
      wait_glitch_fall(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL tie_window: window not seen");
      end
      post_bit = ~post_bit;
      tick(46);
      post_bit = ~post_bit;
      tick(4);
      tests_run++;
      if ({success, hard_reset, busy} !== 3'b100) begin
         tests_failed++;
         $display("FAIL tie_success: s/hr/b=%b, want 100", {success, hard_reset, busy});
      end
      tick(3);
      tests_run++;
      if (hard_reset !== 1'b0 || success !== 1'b1) begin
         tests_failed++;
         $display("FAIL tie_no_reset: hr=%0b success=%0b, want 0 1", hard_reset, success);
      end
      enable = 1'b0;
      tick(4);
   endtask

   // Second edge one cycle too late: timeout must win
   task automatic test_late_edge();
      bit ok;
      enable = 1'b1;
      tick(1);
      arm_attempt(16'd100, 3'd1, 16'd1);
      wait_glitch_fall(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL late_window: window not seen");
      end
      post_bit = ~post_bit;
      tick(47);
      post_bit = ~post_bit;
      tick(3);
      tests_run++;
      if (hard_reset !== 1'b1 || success !== 1'b0) begin
         tests_failed++;
         $display("FAIL late_edge: hr=%0b success=%0b, want 1 0", hard_reset, success);
      end
      enable = 1'b0;
      tick(4);
   endtask

   task automatic test_rst_during_arm();
      bit ok;
      enable = 1'b1;
      tick(1);
      arm_attempt(16'd100, 3'd1, 16'd1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (glitch) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL rst_arm_entry: ARM not reached");
      end
      allow_trunc = 1'b1;
      tick(2);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({glitch, hard_reset, busy, success, fail} !== 5'b0 || try_cnt !== 16'd0 ||
          cfg_start !== 16'd100 || cfg_len !== 3'd1) begin
         tests_failed++;
         $display("FAIL rst_arm: flags=%b try=%0d start=%0d len=%0d, want 00000 0 100 1",
                  {glitch, hard_reset, busy, success, fail}, try_cnt, cfg_start, cfg_len);
      end
      enable = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(3);
      tests_run++;
      if (glitch !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_release: glitch=%0b busy=%0b, want 0 0", glitch, busy);
      end
      allow_trunc = 1'b0;
   endtask

   task automatic test_disable_in_reset();
      bit ok;
      enable = 1'b1;
      tick(1);
      arm_attempt(16'd100, 3'd1, 16'd1);
      wait_glitch_fall(ok);
      wait_hr(1'b1, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL dis_reset_entry: hard_reset never rose");
      end
      enable = 1'b0;
      tick(1);
      tests_run++;
      if ({glitch, hard_reset, busy, success, fail} !== 5'b0 || try_cnt !== 16'd0 ||
          cfg_start !== 16'd100 || cfg_len !== 3'd1) begin
         tests_failed++;
         $display("FAIL disable_reset: flags=%b try=%0d start=%0d len=%0d, want 00000 0 100 1",
                  {glitch, hard_reset, busy, success, fail}, try_cnt, cfg_start, cfg_len);
      end
      tick(4);
   endtask

   initial begin
      test_reset();
      test_glitch_window();
      test_success();
      test_timeout_rearm();
      test_sweep_fail();
      test_success_timeout_tie();
      test_late_edge();
      test_rst_during_arm();
      test_disable_in_reset();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d windows missing, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
